// File: rtl/sr_chain_ctrl_pkg.sv
// Shared definitions for the shift-register chain sequencer: state codes,
// chain width derivation and parameter legality helpers.
package sr_chain_ctrl_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_SETUP = 3'd2;
  localparam logic [2:0] ST_LOW   = 3'd3;
  localparam logic [2:0] ST_HIGH  = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  function automatic int chain_width(input int nbytes);
    return 8 * nbytes;
  endfunction

  // Cycles busy stays high: load + setup + W sck periods + the done cycle.
  function automatic int xfer_cycles(input int nbytes, input int clkdiv);
    return 2 * clkdiv + 2 * clkdiv * chain_width(nbytes) + 1;
  endfunction

  function automatic bit clkdiv_ok(input int clkdiv);
    return (clkdiv >= 2) && (clkdiv <= 255);
  endfunction

  // One idle cycle is needed between transfers before the next accept.
  function automatic bit period_ok(input int period, input int nbytes, input int clkdiv);
    return period >= xfer_cycles(nbytes, clkdiv) + 1;
  endfunction

endpackage

// File: rtl/sr_chain_ctrl_tick.sv
// Phase timer: down-counter reloaded with CLKDIV-1, ticking on the last
// cycle of each CLKDIV-long phase while enabled.
module sr_tick_gen #(
  parameter int CLKDIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(CLKDIV);
  localparam logic [CW-1:0] RELOAD = CW'(CLKDIV - 1);

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst_n || !en || (cnt_reg == '0)) begin
      cnt_reg <= RELOAD;
    end else begin
      cnt_reg <= cnt_reg - CW'(1);
    end
  end

  assign tick = en && (cnt_reg == '0);

endmodule

// File: rtl/sr_chain_ctrl.sv
// Load/shift sequencer for a daisy chain of 8-bit shift registers: pulses the
// load line, then clocks W bits out MSB first while capturing the tail's data.
module sr_chain_ctrl
  import sr_chain_ctrl_pkg::*;
#(
  parameter int NBYTES = 2,
  parameter int CLKDIV = 4,
  parameter int PERIOD = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  auto_en,
  input  logic [8*NBYTES-1:0]   tx_data,
  output logic                  busy,
  output logic                  done,
  output logic [8*NBYTES-1:0]   rx_data,
  output logic                  sr_sck,
  output logic                  sr_ld,
  output logic                  sr_sdo,
  input  logic                  sr_sdi,
  output logic                  sr_stb
);

  localparam int W  = chain_width(NBYTES);
  localparam int BW = $clog2(W);
  localparam int PW = (PERIOD > 2) ? $clog2(PERIOD) : 1;

  if (!clkdiv_ok(CLKDIV)) begin : g_bad_clkdiv
    $error("sr_chain_ctrl: CLKDIV must be within 2..255");
  end
  if (!period_ok(PERIOD, NBYTES, CLKDIV)) begin : g_bad_period
    $error("sr_chain_ctrl: PERIOD shorter than one transfer");
  end

  logic [2:0]    state_reg, state_next;
  logic [W-1:0]  tx_shift_reg, tx_shift_next;
  logic [W-1:0]  rx_shift_reg;
  logic [BW-1:0] bit_cnt_reg;
  logic [PW-1:0] auto_cnt_reg;
  logic          tick, phase_en, auto_fire, accept;

  assign auto_fire = auto_en && (auto_cnt_reg == PW'(PERIOD - 1));
  assign accept    = (state_reg == ST_IDLE) && (start || auto_fire);
  assign phase_en  = (state_reg == ST_LOAD) || (state_reg == ST_SETUP) ||
                     (state_reg == ST_LOW)  || (state_reg == ST_HIGH);

  sr_tick_gen #(.CLKDIV(CLKDIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (phase_en),
    .tick  (tick)
  );

  always_comb begin
    state_next    = state_reg;
    tx_shift_next = tx_shift_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          state_next    = ST_LOAD;
          tx_shift_next = tx_data;
        end
      end
      ST_LOAD:  if (tick) state_next = ST_SETUP;
      ST_SETUP: if (tick) state_next = ST_LOW;
      ST_LOW:   if (tick) state_next = ST_HIGH;
      ST_HIGH: begin
        if (tick) begin
          tx_shift_next = {tx_shift_reg[W-2:0], 1'b0};
          state_next    = (bit_cnt_reg == '0) ? ST_DONE : ST_LOW;
        end
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Outputs decode the next state so they are registered yet aligned with it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      tx_shift_reg <= '0;
      rx_shift_reg <= '0;
      bit_cnt_reg  <= '0;
      auto_cnt_reg <= '0;
      rx_data      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      sr_stb       <= 1'b0;
      sr_sck       <= 1'b1;
      sr_ld        <= 1'b0;
      sr_sdo       <= 1'b0;
    end else begin
      state_reg    <= state_next;
      tx_shift_reg <= tx_shift_next;

      if (state_reg == ST_SETUP) begin
        bit_cnt_reg <= BW'(W - 1);
      end else if ((state_reg == ST_HIGH) && tick && (bit_cnt_reg != '0)) begin
        bit_cnt_reg <= bit_cnt_reg - BW'(1);
      end

      // Sample the tail just before the rising sck edge.
      if ((state_reg == ST_LOW) && tick) begin
        rx_shift_reg <= {rx_shift_reg[W-2:0], sr_sdi};
      end

      if (!auto_en || auto_fire) begin
        auto_cnt_reg <= '0;
      end else begin
        auto_cnt_reg <= auto_cnt_reg + PW'(1);
      end

      if (state_next == ST_DONE) begin
        rx_data <= rx_shift_reg;
      end
      if (state_next == ST_LOW) begin
        sr_sdo <= tx_shift_next[W-1];
      end

      busy   <= (state_next != ST_IDLE);
      done   <= (state_next == ST_DONE);
      sr_stb <= (state_next == ST_DONE);
      sr_sck <= (state_next != ST_LOW);
      sr_ld  <= (state_next == ST_LOAD);
    end
  end

endmodule

// File: tb/tb_sr_chain_ctrl.sv
// Scoreboard bench: loopback through a behavioural 2x8 chain (DUT a) and a
// CLKDIV=5 single-byte instance with the serial input held high (DUT b).
`timescale 1ns/1ps
module tb_sr_chain_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // DUT a: NBYTES=2, CLKDIV=2, PERIOD=100
  logic        rst_n, start_a, auto_en_a, sdi_a;
  logic [15:0] tx_a, rx_a;
  logic        busy_a, done_a, sck_a, ld_a, sdo_a, stb_a;

  sr_chain_ctrl #(.NBYTES(2), .CLKDIV(2), .PERIOD(100)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .auto_en(auto_en_a), .tx_data(tx_a),
    .busy(busy_a), .done(done_a), .rx_data(rx_a), .sr_sck(sck_a), .sr_ld(ld_a),
    .sr_sdo(sdo_a), .sr_sdi(sdi_a), .sr_stb(stb_a)
  );

  // DUT b: NBYTES=1, CLKDIV=5
  logic       start_b, auto_en_b, sdi_b;
  logic [7:0] tx_b, rx_b;
  logic       busy_b, done_b, sck_b, ld_b, sdo_b, stb_b;

  sr_chain_ctrl #(.NBYTES(1), .CLKDIV(5), .PERIOD(4096)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .auto_en(auto_en_b), .tx_data(tx_b),
    .busy(busy_b), .done(done_b), .rx_data(rx_b), .sr_sck(sck_b), .sr_ld(ld_b),
    .sr_sdo(sdo_b), .sr_sdi(sdi_b), .sr_stb(stb_b)
  );

  // Behavioural chain {tail, head}: parallel load on ld, shift on sck rise.
  logic [15:0] chain = 16'h0;
  logic        sck_prev = 1'b1;
  int          sck_rises = 0;
  always @(posedge clk) begin
    sck_prev <= sck_a;
    if (ld_a === 1'b1) begin
      chain     <= 16'hA53C;
      sck_rises <= 0;
    end else if (sck_a === 1'b1 && sck_prev === 1'b0) begin
      chain     <= {chain[14:0], sdo_a};
      sck_rises <= sck_rises + 1;
    end
  end
  assign sdi_a = chain[15];
  assign sdi_b = 1'b1;

  typedef struct packed {
    logic [15:0] rx;
    logic [15:0] chain;
    logic [31:0] done_cyc;
  } exp_a_t;
  typedef struct packed {
    logic [7:0]  rx;
    logic [31:0] done_cyc;
  } exp_b_t;
  exp_a_t q_a[$];
  exp_b_t q_b[$];

  // Monitor a: pops on every done pulse
  logic done_prev_a = 1'b0;
  always @(negedge clk) begin
    exp_a_t e;
    if (done_prev_a) check("done_a_one_cycle", 32'(done_a), 32'd0);
    done_prev_a = (done_a === 1'b1);
    if (stb_a === 1'b1 || done_a === 1'b1) check("stb_a_with_done", 32'(stb_a), 32'(done_a));
    if (done_a === 1'b1) begin
      if (q_a.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL done_a_unexpected: got done at cycle %0d expected none", cyc);
      end else begin
        e = q_a.pop_front();
        $display("xfer a: rx=%h chain=%h at cycle %0d", rx_a, chain, cyc);
        check("done_a_cycle", 32'(cyc), e.done_cyc);
        check("rx_a", 32'(rx_a), 32'(e.rx));
        check("chain_a", 32'(chain), 32'(e.chain));
        check("sck_rises_a", 32'(sck_rises), 32'd16);
      end
    end
  end

  // Monitor b
  always @(negedge clk) begin
    exp_b_t e;
    if (done_b === 1'b1) begin
      if (q_b.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL done_b_unexpected: got done at cycle %0d expected none", cyc);
      end else begin
        e = q_b.pop_front();
        $display("xfer b: rx=%h at cycle %0d", rx_b, cyc);
        check("done_b_cycle", 32'(cyc), e.done_cyc);
        check("rx_b", 32'(rx_b), 32'(e.rx));
        check("stb_b", 32'(stb_b), 32'd1);
      end
    end
  end

  // Waveform timing on dut a: ld width, setup gap, sck phase widths, busy length
  int   ld_run = 0, setup_run = -1, low_run = 0, high_run = 0, busy_run = 0;
  bit   in_shift = 0, done_seen = 0;
  logic sck_q = 1'b1, ld_q = 1'b0, busy_q = 1'b0;
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (ld_a === 1'b1) begin
        check("ld_while_sck_low", 32'(sck_a), 32'd1);
        ld_run++;
      end else if (ld_q === 1'b1) begin
        check("ld_width", 32'(ld_run), 32'd2);
        ld_run    = 0;
        setup_run = 0;
      end
      if (setup_run >= 0) begin
        if (sck_a === 1'b0) begin
          check("setup_width", 32'(setup_run), 32'd2);
          setup_run = -1;
        end else begin
          setup_run++;
        end
      end
      if (sck_a === 1'b0) begin
        if (sck_q === 1'b1 && in_shift) check("sck_high_width", 32'(high_run), 32'd2);
        low_run++;
        high_run = 0;
        in_shift = 1;
      end else begin
        if (sck_q === 1'b0) begin
          check("sck_low_width", 32'(low_run), 32'd2);
          low_run = 0;
        end
        high_run++;
      end
      if (ld_a === 1'b1) in_shift = 0;
      if (busy_a === 1'b1) begin
        busy_run++;
        if (done_a === 1'b1) done_seen = 1;
      end else if (busy_q === 1'b1) begin
        if (done_seen) check("busy_width", 32'(busy_run), 32'd69);
        busy_run  = 0;
        done_seen = 0;
      end
    end else begin
      ld_run = 0; setup_run = -1; low_run = 0; high_run = 0;
      busy_run = 0; in_shift = 0; done_seen = 0;
    end
    sck_q  = sck_a;
    ld_q   = ld_a;
    busy_q = busy_a;
  end

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic wait_idle_a();
    int n = 0;
    while (busy_a === 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("a_idle_within_bound", 32'(busy_a), 32'd0);
  endtask

  task automatic start_a_xfer(input logic [15:0] tx, input bit expect_done);
    exp_a_t e;
    tx_a    = tx;
    start_a = 1'b1;
    if (expect_done) begin
      e.rx       = 16'hA53C;
      e.chain    = tx;
      e.done_cyc = 32'(cyc + 1 + 68);
      q_a.push_back(e);
    end
    @(negedge clk);
    start_a = 1'b0;
  endtask

  initial begin
    int acc, c;
    exp_a_t ea;
    exp_b_t eb;
    rst_n = 1'b0; start_a = 1'b0; auto_en_a = 1'b0; tx_a = '0;
    start_b = 1'b0; auto_en_b = 1'b0; tx_b = '0;
    repeat (3) @(negedge clk);
    check("rst_sck", 32'(sck_a), 32'd1);
    check("rst_ld", 32'(ld_a), 32'd0);
    check("rst_sdo", 32'(sdo_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_stb", 32'(stb_a), 32'd0);
    check("rst_rx", 32'(rx_a), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Loopback transfer with ignored starts and tx_data changes while busy
    acc = cyc + 1;
    start_a_xfer(16'h1234, 1'b1);
    tx_a = 16'hFFFF;
    wait_until(acc + 9);
    check("busy_at_plus10", 32'(busy_a), 32'd1);
    start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    tx_a = 16'h0000;
    wait_until(acc + 39);
    check("busy_at_plus40", 32'(busy_a), 32'd1);
    start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    wait_idle_a();
    repeat (3) @(negedge clk);

    start_a_xfer(16'hBEEF, 1'b1);
    wait_idle_a();
    repeat (5) @(negedge clk);

    // Auto mode: wraps at c+100 and c+200; the second coincides with start
    c = cyc;
    tx_a = 16'h0F0F;
    auto_en_a = 1'b1;
    ea.rx = 16'hA53C; ea.chain = 16'h0F0F; ea.done_cyc = 32'(c + 100 + 68);
    q_a.push_back(ea);
    wait_until(c + 180);
    tx_a = 16'hC3C3;
    wait_until(c + 199);
    ea.chain = 16'hC3C3; ea.done_cyc = 32'(c + 200 + 68);
    q_a.push_back(ea);
    start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    wait_until(c + 250);
    auto_en_a = 1'b0;
    wait_until(c + 420);
    check("auto_off_idle", 32'(busy_a), 32'd0);

    // Reset in the HIGH phase of bit counter 7 abandons the transfer
    acc = cyc + 1;
    start_a_xfer(16'h5555, 1'b0);
    wait_until(acc + 38);
    check("pre_reset_sck_high", 32'(sck_a), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_sck", 32'(sck_a), 32'd1);
    check("midrst_ld", 32'(ld_a), 32'd0);
    check("midrst_busy", 32'(busy_a), 32'd0);
    check("midrst_rx", 32'(rx_a), 32'd0);
    check("midrst_done", 32'(done_a), 32'd0);
    wait_until(acc + 90);
    start_a_xfer(16'h9999, 1'b1);
    wait_idle_a();

    // DUT b: CLKDIV=5, NBYTES=1, serial input tied high
    repeat (3) @(negedge clk);
    tx_b = 8'h5A;
    eb.rx = 8'hFF; eb.done_cyc = 32'(cyc + 1 + 90);
    q_b.push_back(eb);
    start_b = 1'b1; @(negedge clk); start_b = 1'b0;
    begin
      int n = 0;
      while (busy_b === 1'b1 && n < 300) begin
        @(negedge clk);
        n++;
      end
    end
    check("b_idle_within_bound", 32'(busy_b), 32'd0);

    repeat (5) @(negedge clk);
    check("q_a_drained", 32'(q_a.size()), 32'd0);
    check("q_b_drained", 32'(q_b.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
